// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I front end.
//   ERR_INSTR        : word that instruction memory returns for a bad fetch
//   DEFAULT_RESET_PC : default boot offset from the instruction-memory base
//   fetch_state_t    : fetch controller state
//   align_word()     : clears the byte-offset bits of an address
package rv32i_pkg;

    localparam logic [31:0] ERR_INSTR        = 32'hDEADBEEF;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-to-decode handshake.
//   valid_o    : head of the instruction queue is valid
//   ready_i    : decode accepts the head this cycle
//   instr_o    : head instruction word
//   instr_pc_o : PC of the head instruction
// master = fetch side, slave = decode side.
interface fetch_stage_if;

    logic        valid_o;
    logic        ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;

    modport master (
        output valid_o,
        output instr_o,
        output instr_pc_o,
        input  ready_i
    );

    modport slave (
        input  valid_o,
        input  instr_o,
        input  instr_pc_o,
        output ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction queue holding {pc, instr} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the queue; overrides push and pop
//   push       : write push_data (accepted when not full, or when full with pop)
//   pop        : drop the head entry (ignored when empty)
//   count      : number of valid entries
//   head_data  : registered head entry (zero after reset)
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok    = pop && (count != '0);
    assign push_ok   = push && ((count < CW'(DEPTH)) || pop_ok);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // When full, wr_ptr == rd_ptr: overwriting the slot being popped is safe.
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/FAULT controller and instruction queue.
//   clk, rst_n    : clock, asynchronous active-low reset
//   pc_o          : fetch address (base-relative) to instruction memory
//   instr_i       : word returned combinationally for pc_o
//   redirect_i    : flush queue and restart fetch at redirect_pc_i
//   redirect_pc_i : restart address; a misaligned one faults
//   fault_o       : fetch halted on error word or misaligned redirect
//   deq           : queue head handshake toward decode
//
// state | meaning
// RUN   | fetching one word per cycle while the queue has room
// FAULT | fetch halted; queue drains; leave only via aligned redirect
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [31:0]   pc_o,
    input  logic [31:0]   instr_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    output logic          fault_o,
    fetch_stage_if.master deq
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t  state, state_next;
    logic [31:0]   pc_next;
    logic          push;
    logic          pop;
    logic          valid;
    logic [CW-1:0] count;
    logic [63:0]   head_data;

    assign valid       = (count != '0);
    assign deq.valid_o = valid;
    assign {deq.instr_pc_o, deq.instr_o} = head_data;
    assign fault_o     = (state == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc_o  <= RESET_PC;
        end else begin
            state <= state_next;
            pc_o  <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc_o;
        push       = 1'b0;
        pop        = valid && deq.ready_i && !redirect_i;
        if (redirect_i) begin
            pc_next    = align_word(redirect_pc_i);
            state_next = (redirect_pc_i[1:0] != 2'b00) ? FAULT : RUN;
        end else if (state == RUN && ((count < CW'(DEPTH)) || pop)) begin
            // The error word is never queued; the PC stays on it.
            if (instr_i == ERR_INSTR) begin
                state_next = FAULT;
            end else begin
                push    = 1'b1;
                pc_next = pc_o + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_i),
        .push      (push),
        .pop       (pop),
        .push_data ({pc_o, instr_i}),
        .count     (count),
        .head_data (head_data)
    );

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import rv32i_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        redirect = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        fault;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic        m_fault;

    fetch_stage_if bus ();

    always #5 clk = ~clk;

    // Instruction memory: error word at 0x1000 and 0xC8, hashed data elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h1000 || a == 32'hC8) return ERR_INSTR;
        w = (a * 32'h9E3779B1) ^ 32'h0F0F_1234;
        if (w == ERR_INSTR) w = 32'h0;
        return w;
    endfunction

    assign instr = mem_word(pc);

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_o          (pc),
        .instr_i       (instr),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc),
        .fault_o       (fault),
        .deq           (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
    endtask

    // One clock of the fetch rules, applied to the inputs held over the edge.
    task automatic model_update();
        bit          do_pop;
        bit          room;
        logic [31:0] w;
        if (redirect) begin
            mq.delete();
            m_pc    = {rpc[31:2], 2'b00};
            m_fault = (rpc[1:0] != 2'b00);
        end else begin
            do_pop = (mq.size() != 0) && bus.ready_i;
            room   = (mq.size() < DEPTH) || do_pop;
            if (do_pop) void'(mq.pop_front());
            if (!m_fault && room) begin
                w = mem_word(m_pc);
                if (w == ERR_INSTR) begin
                    m_fault = 1'b1;
                end else begin
                    mq.push_back({m_pc, w});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("pc", pc, m_pc);
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        chk("valid", {31'b0, bus.valid_o}, {31'b0, (mq.size() != 0)});
        if (mq.size() != 0) begin
            chk("instr", bus.instr_o, mq[0][31:0]);
            chk("instr_pc", bus.instr_pc_o, mq[0][63:32]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_model();
    endtask

    // Called 1ns after an edge: reset must take effect with no clock edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_valid", {31'b0, bus.valid_o}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_instr_pc", bus.instr_pc_o, 32'h0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.ready_i = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Streaming with decode always ready
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", {31'b0, bus.valid_o}, 32'h1);
            chk("stream_pc", bus.instr_pc_o, 32'(4 * i));
            chk("stream_instr", bus.instr_o, mem_word(32'(4 * i)));
        end

        // Backpressure: queue fills to DEPTH, PC stalls at 8
        apply_reset();
        bus.ready_i = 1'b0;
        repeat (5) step();
        chk("stall_pc", pc, 32'h8);
        chk("stall_head", bus.instr_pc_o, 32'h0);
        bus.ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drain_pc", bus.instr_pc_o, 32'(4 * (i + 1)));
        end

        // Redirect beats pop on a full queue
        bus.ready_i = 1'b0;
        repeat (3) step();
        bus.ready_i = 1'b1;
        redirect = 1'b1;
        rpc = 32'h40;
        step();
        chk("redir_valid", {31'b0, bus.valid_o}, 32'h0);
        redirect = 1'b0;
        step();
        chk("redir_head", bus.instr_pc_o, 32'h40);

        // Error word at 0x1000
        redirect = 1'b1;
        rpc = 32'hFF0;
        step();
        redirect = 1'b0;
        repeat (8) step();
        chk("err_fault", {31'b0, fault}, 32'h1);
        chk("err_pc", pc, 32'h1000);
        chk("err_drained", {31'b0, bus.valid_o}, 32'h0);
        redirect = 1'b1;
        rpc = 32'h0;
        step();
        chk("recover_fault", {31'b0, fault}, 32'h0);
        redirect = 1'b0;
        step();
        chk("recover_head", bus.instr_pc_o, 32'h0);

        // Misaligned redirect
        redirect = 1'b1;
        rpc = 32'h22;
        step();
        chk("mis_pc", pc, 32'h20);
        chk("mis_fault", {31'b0, fault}, 32'h1);
        redirect = 1'b0;
        repeat (4) step();
        chk("mis_nopush", {31'b0, bus.valid_o}, 32'h0);
        chk("mis_hold", pc, 32'h20);
        redirect = 1'b1;
        rpc = 32'h100;
        step();
        chk("mis_exit", {31'b0, fault}, 32'h0);

        // PC wrap
        rpc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        repeat (2) step();
        chk("wrap_pc", pc, 32'h0);
        step();

        // Mid-stream reset with the queue full
        bus.ready_i = 1'b0;
        repeat (3) step();
        apply_reset();
        bus.ready_i = 1'b1;
        step();
        chk("post_rst_head", bus.instr_pc_o, 32'h0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            bus.ready_i = ($urandom % 4) != 0;
            redirect    = ($urandom % 16) == 0;
            rpc         = 32'($urandom_range(0, 80) * 4) + ((($urandom % 5) == 0) ? 32'h2 : 32'h0);
            if (($urandom % 97) == 0) begin
                apply_reset();
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
